natural_log_arbiter: RTL and testbench

//  Shares one pipelined natural_log unit among N_REQ requesters (diode/transistor

---
 rtl/natural_log_arbiter_if.sv | 27 ++
 rtl/natural_log_arbiter.sv | 119 +++++++++++
 tb/tb_natural_log_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/natural_log_arbiter_if.sv
// Bundle between the requesters / shared natural_log unit and the arbiter.
interface natural_log_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*24-1:0] req_data;
  logic [23:0]         log_in;
  logic [11:0]         log_out;
  logic [N_REQ-1:0]    resp_valid;
  logic [11:0]         resp_data;
  logic [IDW-1:0]      resp_id;
  logic [3+IDW-1:0]    inflight;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, log_out,
    output req_ready, log_in, resp_valid, resp_data, resp_id, inflight
  );

  // Requester / log-unit side
  modport master (
    output req_valid, req_data, log_out,
    input  req_ready, log_in, resp_valid, resp_data, resp_id, inflight
  );
endinterface

// File: rtl/natural_log_arbiter.sv
// Round-robin arbiter feeding one shared pipelined natural_log unit; a tag
// pipeline matched to the log latency routes each result to its requester.
module natural_log_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LOG_LATENCY = 3,
  parameter int IDW         = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  natural_log_arbiter_if.slave bus
);
  localparam int unsigned DW  = 24;
  localparam int unsigned RW  = 12;
  localparam int unsigned IFW = 3 + IDW;
  localparam int unsigned NST = LOG_LATENCY + 1;

  logic [IDW-1:0]   r_ptr;
  logic [DW-1:0]    r_log_in;
  logic             r_tag_v  [NST];
  logic [IDW-1:0]   r_tag_id [NST];
  logic [N_REQ-1:0] r_resp_valid;
  logic [RW-1:0]    r_resp_data;
  logic [IDW-1:0]   r_resp_id;
  logic [IFW-1:0]   r_inflight;

  logic             w_grant_vld;
  logic [IDW-1:0]   w_grant_id;
  logic [DW-1:0]    w_grant_data;
  logic [N_REQ-1:0] w_ready;
  logic             w_resp_any;
  logic [IDW-1:0]   w_ptr_next;

  // First valid requester at or after the pointer, wrapping; nothing granted in reset
  always_comb begin
    int v_idx;
    v_idx        = 0;
    w_grant_vld  = 1'b0;
    w_grant_id   = '0;
    w_grant_data = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = (int'(r_ptr) + k) % N_REQ;
      if (bus.req_valid[v_idx]) begin
        w_grant_vld  = 1'b1;
        w_grant_id   = IDW'(v_idx);
        w_grant_data = bus.req_data[v_idx*int'(DW) +: DW];
      end
    end
    if (reset) begin
      w_grant_vld = 1'b0;
    end
    w_ready = w_grant_vld ? (N_REQ'(1) << w_grant_id) : '0;
  end

  assign w_resp_any = |r_resp_valid;
  assign w_ptr_next = (w_grant_id == IDW'(N_REQ - 1)) ? '0 : w_grant_id + IDW'(1);

  // Operand register and round-robin pointer, updated only on a transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_log_in <= '0;
      r_ptr    <= '0;
    end else if (w_grant_vld) begin
      r_log_in <= w_grant_data;
      r_ptr    <= w_ptr_next;
    end
  end

  // Tag pipeline shifts every cycle so it stays aligned with the log unit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NST; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_grant_vld;
      r_tag_id[0] <= w_grant_id;
      for (int unsigned s = 1; s < NST; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Result strobe: one-hot decode of the last tag, data captured from log_out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
    end else begin
      r_resp_valid <= r_tag_v[NST-1] ? (N_REQ'(1) << r_tag_id[NST-1]) : '0;
      if (r_tag_v[NST-1]) begin
        r_resp_data <= bus.log_out;
        r_resp_id   <= r_tag_id[NST-1];
      end
    end
  end

  // Outstanding-operation counter: issue increments, delivered result decrements
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_grant_vld, w_resp_any})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.log_in     = r_log_in;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;
  assign bus.inflight   = r_inflight;
endmodule

// File: tb/tb_natural_log_arbiter.sv
// Bench for natural_log_arbiter: stand-in 3-stage natural_log unit, queue-based
// reference model, vector table for arbitration order, directed corner cases
// and a randomized run with requesters that hold or drop their requests.
module tb_natural_log_arbiter;
  localparam int N   = 4;
  localparam int L   = 3;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  natural_log_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

  natural_log_arbiter #(.N_REQ(N), .LOG_LATENCY(L), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ln() in 8-frac fixed point, clamped below at 0x104 and saturated at 12-bit max
  function automatic logic [11:0] ln_fx(input logic [23:0] x);
    real r;
    logic [23:0] xc;
    xc = (x < 24'h104) ? 24'h104 : x;
    r  = $ln(real'(xc) / 256.0) * 256.0;
    if (r > 2047.0) r = 2047.0;
    return 12'($rtoi(r + 0.5));
  endfunction

  // Stand-in shared log unit with LOG_LATENCY register stages
  logic [11:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= ln_fx(bus.log_in);
    p2 <= p1;
    p3 <= p2;
  end
  assign bus.log_out = p3;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int due; int id; logic [23:0] data; } exp_t;
  exp_t        q[$];
  int          m_ptr = 0;
  int          m_n = 0;
  int          m_infl = 0;
  logic        m_rv = 1'b0;
  int          m_rid = 0;
  logic [23:0] m_rdata = '0;
  logic [23:0] m_log_in = '0;
  logic        m_just_rst = 1'b0;

  // One clock: drive at negedge, check grant, advance model at posedge, check outputs
  task automatic step(input logic [3:0] v, input logic [95:0] d, input logic rst,
                      output logic [3:0] got_ready);
    int   mg;
    logic mg_v;
    @(negedge clk);
    reset         = rst;
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
    mg = 0;
    mg_v = 1'b0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (!mg_v && v[(m_ptr + k) % N]) begin
          mg_v = 1'b1;
          mg   = (m_ptr + k) % N;
        end
      end
    end
    got_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, mg_v ? (1 << mg) : 0);
    @(posedge clk);
    m_n++;
    if (rst) begin
      m_ptr = 0; q.delete(); m_infl = 0; m_log_in = '0;
      m_rv = 1'b0; m_rid = 0; m_just_rst = 1'b1;
    end else begin
      m_just_rst = 1'b0;
      if (m_rv) m_infl--;
      if (mg_v) m_infl++;
      m_rv = 1'b0;
      if (q.size() > 0 && q[0].due == m_n) begin
        m_rv = 1'b1; m_rid = q[0].id; m_rdata = q[0].data;
        void'(q.pop_front());
      end
      if (mg_v) begin
        m_log_in = d[mg*24 +: 24];
        q.push_back('{due: m_n + L + 1, id: mg, data: d[mg*24 +: 24]});
        m_ptr = (mg + 1) % N;
      end
    end
    #1;
    chk("resp_valid", bus.resp_valid, m_rv ? (1 << m_rid) : 0);
    if (m_rv) begin
      chk("resp_id", bus.resp_id, m_rid);
      chk("resp_data", bus.resp_data, ln_fx(m_rdata));
    end
    if (m_just_rst) begin
      chk("rst_resp_data", bus.resp_data, 0);
      chk("rst_resp_id", bus.resp_id, 0);
    end
    chk("log_in", bus.log_in, m_log_in);
    chk("inflight", bus.inflight, m_infl);
  endtask

  task automatic idle(input int cycles);
    logic [3:0] r;
    for (int i = 0; i < cycles; i++) step(4'b0000, '0, 1'b0, r);
  endtask

  task automatic do_reset(input int cycles);
    logic [3:0] r;
    for (int i = 0; i < cycles; i++) step(4'b0000, '0, 1'b1, r);
  endtask

  // Arbitration vectors applied in order straight after reset (pointer starts at 0)
  typedef struct { logic [3:0] valid; logic [3:0] exp_ready; } vec_t;
  vec_t tbl[10];

  logic [3:0]  rdy;
  logic [95:0] d;
  int          lat, cnt, first_c, last_c, peak, any_resp;
  logic [11:0] rdat;
  logic        pend_v [N];
  logic [23:0] pend_d [N];
  logic [3:0]  rv;

  initial begin
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001};
    tbl[3] = '{4'b1000, 4'b1000};
    tbl[4] = '{4'b0000, 4'b0000};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0011, 4'b0001};
    tbl[7] = '{4'b1100, 4'b0100};
    tbl[8] = '{4'b0101, 4'b0001};
    tbl[9] = '{4'b1111, 4'b0010};

    bus.req_valid = '0;
    bus.req_data  = '0;
    do_reset(2);

    // Table-driven arbitration order
    for (int r = 0; r < 10; r++) begin
      for (int ln = 0; ln < N; ln++) d[ln*24 +: 24] = 24'(24'h400 + 16*r + ln);
      step(tbl[r].valid, d, 1'b0, rdy);
      chk($sformatf("tbl%0d_ready", r), rdy, tbl[r].exp_ready);
    end
    idle(L + 3);

    // Req0 operand 2.0: immediate accept, result ln2 after the pipeline latency
    d = '0; d[23:0] = 24'h000200;
    step(4'b0001, d, 1'b0, rdy);
    chk("t1_accept", rdy, 4'b0001);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (lat < 0 && bus.resp_valid[0]) begin lat = k; rdat = bus.resp_data; end
    end
    chk("t1_latency_edges", lat, L + 1);
    chk("t1_ln2_in_range", (rdat >= 175 && rdat <= 179), 1);

    // Req2 operand ~e: resp_id 2, result ~256
    d = '0; d[48 +: 24] = 24'h0002B8;
    step(4'b0100, d, 1'b0, rdy);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (lat < 0 && bus.resp_valid[2]) begin lat = k; rdat = bus.resp_data; chk("t2_id", bus.resp_id, 2); end
    end
    chk("t2_seen", lat, L + 1);
    chk("t2_lne_in_range", (rdat >= 254 && rdat <= 258), 1);

    // All four valid for 8 cycles from a fresh pointer: grants rotate
    do_reset(1);
    peak = 0;
    for (int k = 0; k < 8; k++) begin
      for (int ln = 0; ln < N; ln++) d[ln*24 +: 24] = 24'(24'h1000 * (k + 1) + 24'h111 * ln);
      step(4'b1111, d, 1'b0, rdy);
      chk($sformatf("t3_grant%0d", k), rdy, 1 << (k % N));
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
    end
    for (int k = 0; k < L + 3; k++) begin
      idle(1);
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
    end
    chk("t3_peak_bounded", (peak <= L + 2), 1);

    // Req1 continuously valid 10 cycles: 10 accepts, 10 consecutive strobes
    cnt = 0; first_c = -1; last_c = -1;
    d = '0;
    for (int k = 0; k < 10 + L + 3; k++) begin
      d[24 +: 24] = 24'(24'h300 + 7*k);
      if (k < 10) begin
        step(4'b0010, d, 1'b0, rdy);
        if (rdy[1]) cnt++;
      end else begin
        idle(1);
      end
      if (bus.resp_valid[1]) begin
        if (first_c < 0) first_c = k;
        last_c = k;
      end
    end
    chk("t4_accepts", cnt, 10);
    chk("t4_strobe_span", last_c - first_c + 1, 10);

    // Operand 1.0 passes through unchanged; clamp result comes from the log unit
    d = '0; d[23:0] = 24'h000100;
    step(4'b0001, d, 1'b0, rdy);
    chk("t6_log_in", bus.log_in, 24'h000100);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (lat < 0 && bus.resp_valid[0]) begin lat = k; rdat = bus.resp_data; end
    end
    chk("t6_clamp_result", (lat > 0 && rdat >= 2 && rdat <= 6), 1);

    // Issue 3 ops, reset just before the first would return: nothing comes back
    for (int k = 0; k < 3; k++) begin
      for (int ln = 0; ln < N; ln++) d[ln*24 +: 24] = 24'(24'h2000 + 24'h10 * k + ln);
      step(4'b1111, d, 1'b0, rdy);
    end
    do_reset(1);
    any_resp = 0;
    for (int k = 0; k < 2 * L; k++) begin
      idle(1);
      if (bus.resp_valid != 0) any_resp++;
    end
    chk("t5_no_stale_resp", any_resp, 0);
    chk("t5_inflight_zero", bus.inflight, 0);
    d = '1;
    step(4'b1111, d, 1'b0, rdy);
    chk("t5_ptr_zero", rdy, 4'b0001);
    idle(L + 3);

    // Randomized requesters: hold until accepted, occasional drop, rare reset
    for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_d[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i] = 1'b1;
          pend_d[i] = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 24'h300))
                                                   : 24'($urandom);
        end else if (pend_v[i] && $urandom_range(0, 15) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        rv[i] = pend_v[i];
        d[i*24 +: 24] = pend_d[i];
      end
      step(rv, d, ($urandom_range(0, 99) == 0), rdy);
      for (int i = 0; i < N; i++) if (rdy[i]) pend_v[i] = 1'b0;
    end
    idle(L + 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
